// File: rtl/multicycle_controller_pkg.sv
// Shared definitions for the multi-cycle sequencer: opcodes, state codes,
// ALUOp / pc_src codes and the registered control word.
package multicycle_controller_pkg;

   localparam int ISA_WIDTH = 32;

   localparam logic [5:0] OP_RTYPE = 6'h00;
   localparam logic [5:0] OP_J     = 6'h02;
   localparam logic [5:0] OP_JAL   = 6'h03;
   localparam logic [5:0] OP_BEQ   = 6'h04;
   localparam logic [5:0] OP_BNE   = 6'h05;
   localparam logic [5:0] OP_ADDI  = 6'h08;
   localparam logic [5:0] OP_ADDIU = 6'h09;
   localparam logic [5:0] OP_SLTI  = 6'h0A;
   localparam logic [5:0] OP_SLTIU = 6'h0B;
   localparam logic [5:0] OP_ANDI  = 6'h0C;
   localparam logic [5:0] OP_ORI   = 6'h0D;
   localparam logic [5:0] OP_XORI  = 6'h0E;
   localparam logic [5:0] OP_LUI   = 6'h0F;
   localparam logic [5:0] OP_LW    = 6'h23;
   localparam logic [5:0] OP_SW    = 6'h2B;

   localparam logic [5:0] FUNCT_JR = 6'h08;

   typedef enum logic [2:0] {
      ST_FETCH  = 3'd0,
      ST_DECODE = 3'd1,
      ST_EXEC   = 3'd2,
      ST_MEM    = 3'd3,
      ST_WB     = 3'd4
   } state_t;

   localparam logic [1:0] ALUOP_ADD    = 2'b00;
   localparam logic [1:0] ALUOP_SUB    = 2'b01;
   localparam logic [1:0] ALUOP_FUNCT  = 2'b10;
   localparam logic [1:0] ALUOP_ILOGIC = 2'b11;

   localparam logic [1:0] PC_PLUS4  = 2'b00;
   localparam logic [1:0] PC_BRANCH = 2'b01;
   localparam logic [1:0] PC_JUMP   = 2'b10;
   localparam logic [1:0] PC_REG    = 2'b11;

   // Instruction class steers EXEC/MEM/WB sequencing.
   typedef enum logic [3:0] {
      CLS_NONE   = 4'd0,
      CLS_ALU    = 4'd1,
      CLS_JAL    = 4'd2,
      CLS_LW     = 4'd3,
      CLS_SW     = 4'd4,
      CLS_BEQ    = 4'd5,
      CLS_BNE    = 4'd6,
      CLS_J      = 4'd7,
      CLS_JR     = 4'd8
   } instr_class_t;

   typedef struct packed {
      instr_class_t cls;
      logic         reg_dst;
      logic         mem_to_reg;
      logic         jal;
      logic         alu_src;
      logic [1:0]   alu_op;
   } ctrl_t;

endpackage

// File: rtl/multicycle_controller_opcode_decode.sv
// Combinational opcode/funct decode into the control word and an illegal flag.
module opcode_decode
   import multicycle_controller_pkg::*;
(
   input  logic [5:0] opcode,
   input  logic [5:0] funct,
   output ctrl_t      ctrl,
   output logic       illegal
);

   always_comb begin
      ctrl.cls        = CLS_NONE;
      ctrl.reg_dst    = 1'b0;
      ctrl.mem_to_reg = 1'b0;
      ctrl.jal        = 1'b0;
      ctrl.alu_src    = 1'b0;
      ctrl.alu_op     = ALUOP_ADD;
      illegal         = 1'b0;
      case (opcode)
         OP_RTYPE: begin
            ctrl.cls     = (funct == FUNCT_JR) ? CLS_JR : CLS_ALU;
            ctrl.reg_dst = 1'b1;
            ctrl.alu_op  = ALUOP_FUNCT;
         end
         OP_LW: begin
            ctrl.cls        = CLS_LW;
            ctrl.mem_to_reg = 1'b1;
            ctrl.alu_src    = 1'b1;
         end
         OP_SW: begin
            ctrl.cls     = CLS_SW;
            ctrl.alu_src = 1'b1;
         end
         OP_BEQ: begin
            ctrl.cls    = CLS_BEQ;
            ctrl.alu_op = ALUOP_SUB;
         end
         OP_BNE: begin
            ctrl.cls    = CLS_BNE;
            ctrl.alu_op = ALUOP_SUB;
         end
         OP_J:   ctrl.cls = CLS_J;
         OP_JAL: begin
            ctrl.cls = CLS_JAL;
            ctrl.jal = 1'b1;
         end
         OP_ADDI, OP_ADDIU: begin
            ctrl.cls     = CLS_ALU;
            ctrl.alu_src = 1'b1;
         end
         OP_SLTI, OP_SLTIU, OP_ANDI, OP_ORI, OP_XORI, OP_LUI: begin
            ctrl.cls     = CLS_ALU;
            ctrl.alu_src = 1'b1;
            ctrl.alu_op  = ALUOP_ILOGIC;
         end
         // An unknown opcode leaves an all-zero control word behind.
         default: illegal = 1'b1;
      endcase
   end

endmodule

// File: rtl/multicycle_controller.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB sequencer with a memory ready/timeout
// handshake, registered control word and a retired-instruction counter.
module multicycle_controller
   import multicycle_controller_pkg::*;
#(
   parameter int MEM_TIMEOUT = 16
)
(
   input  logic                 clock,
   input  logic                 reset,
   input  logic [ISA_WIDTH-1:0] Instruction,
   input  logic                 zero,
   input  logic                 mem_ready,
   input  logic                 hold,
   output logic                 ir_load,
   output logic                 pc_en,
   output logic [1:0]           pc_src,
   output logic                 RegWrite,
   output logic                 RegDst,
   output logic                 MemtoReg,
   output logic                 Jal,
   output logic                 ALUSrc,
   output logic [1:0]           ALUOp,
   output logic                 MemRead,
   output logic                 MemWrite,
   output logic                 illegal_op,
   output logic                 bus_error,
   output logic [31:0]          retire_count,
   output logic [2:0]           state
);

   localparam logic [7:0] TMO_LAST = 8'(MEM_TIMEOUT - 1);

   state_t      state_reg, state_next;
   ctrl_t       ctrl_reg, ctrl_dec;
   logic        illegal_dec;
   logic [7:0]  tmo_count_reg;
   logic [31:0] retire_count_reg;
   logic        mem_timeout;
   logic        unused_instr_bits;

   opcode_decode u_decode (
      .opcode  (Instruction[ISA_WIDTH-1 -: 6]),
      .funct   (Instruction[5:0]),
      .ctrl    (ctrl_dec),
      .illegal (illegal_dec)
   );

   assign unused_instr_bits = ^Instruction[ISA_WIDTH-7:6];
   assign mem_timeout       = (tmo_count_reg == TMO_LAST);

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) state_reg <= ST_FETCH;
      else        state_reg <= state_next;
   end

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         ST_FETCH:  if (!hold) state_next = ST_DECODE;
         ST_DECODE: state_next = illegal_dec ? ST_FETCH : ST_EXEC;
         ST_EXEC: begin
            case (ctrl_reg.cls)
               CLS_LW, CLS_SW:   state_next = ST_MEM;
               CLS_ALU, CLS_JAL: state_next = ST_WB;
               default:          state_next = ST_FETCH;
            endcase
         end
         ST_MEM: begin
            // A ready strobe in the last timeout cycle still completes normally.
            if (mem_ready)        state_next = (ctrl_reg.cls == CLS_LW) ? ST_WB : ST_FETCH;
            else if (mem_timeout) state_next = ST_FETCH;
         end
         default: state_next = ST_FETCH;
      endcase
   end

   // Pulses are gated by reset so an abort silences them in the same cycle.
   always_comb begin
      ir_load    = 1'b0;
      pc_en      = 1'b0;
      pc_src     = PC_PLUS4;
      RegWrite   = 1'b0;
      MemRead    = 1'b0;
      MemWrite   = 1'b0;
      illegal_op = 1'b0;
      bus_error  = 1'b0;
      if (reset) begin
         case (state_reg)
            ST_FETCH: ir_load = !hold;
            ST_DECODE: begin
               illegal_op = illegal_dec;
               pc_en      = illegal_dec;
            end
            ST_EXEC: begin
               case (ctrl_reg.cls)
                  CLS_BEQ: begin
                     pc_en  = 1'b1;
                     pc_src = zero ? PC_BRANCH : PC_PLUS4;
                  end
                  CLS_BNE: begin
                     pc_en  = 1'b1;
                     pc_src = zero ? PC_PLUS4 : PC_BRANCH;
                  end
                  CLS_J: begin
                     pc_en  = 1'b1;
                     pc_src = PC_JUMP;
                  end
                  CLS_JR: begin
                     pc_en  = 1'b1;
                     pc_src = PC_REG;
                  end
                  default: ;
               endcase
            end
            ST_MEM: begin
               MemRead  = (ctrl_reg.cls == CLS_LW);
               MemWrite = (ctrl_reg.cls == CLS_SW);
               if (mem_ready) begin
                  pc_en = (ctrl_reg.cls == CLS_SW);
               end else if (mem_timeout) begin
                  bus_error = 1'b1;
                  pc_en     = 1'b1;
               end
            end
            ST_WB: begin
               RegWrite = 1'b1;
               pc_en    = 1'b1;
               pc_src   = (ctrl_reg.cls == CLS_JAL) ? PC_JUMP : PC_PLUS4;
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset)                    ctrl_reg <= '0;
      else if (state_reg == ST_DECODE) ctrl_reg <= ctrl_dec;
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset)                 tmo_count_reg <= 8'd0;
      else if (state_reg != ST_MEM) tmo_count_reg <= 8'd0;
      else                        tmo_count_reg <= tmo_count_reg + 8'd1;
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset)
         retire_count_reg <= 32'd0;
      else if (pc_en && !illegal_op && !bus_error)
         retire_count_reg <= retire_count_reg + 32'd1;
   end

   assign RegDst       = ctrl_reg.reg_dst;
   assign MemtoReg     = ctrl_reg.mem_to_reg;
   assign Jal          = ctrl_reg.jal;
   assign ALUSrc       = ctrl_reg.alu_src;
   assign ALUOp        = ctrl_reg.alu_op;
   assign retire_count = retire_count_reg;
   assign state        = state_reg;

endmodule

// File: tb/tb_multicycle_controller.sv
// Randomised bench for multicycle_controller: a per-instruction model expands
// each instruction into its expected cycle-by-cycle outputs, checked each cycle.
module tb_multicycle_controller;

   localparam int TMO = 16;

   logic        clock = 1'b0;
   logic        reset = 1'b0;
   logic [31:0] Instruction = 32'd0;
   logic        zero = 1'b0, mem_ready = 1'b0, hold = 1'b0;
   logic        ir_load, pc_en, RegWrite, RegDst, MemtoReg, Jal, ALUSrc;
   logic        MemRead, MemWrite, illegal_op, bus_error;
   logic [1:0]  pc_src, ALUOp;
   logic [31:0] retire_count;
   logic [2:0]  state;

   multicycle_controller #(.MEM_TIMEOUT(TMO)) dut (
      .clock(clock), .reset(reset), .Instruction(Instruction), .zero(zero),
      .mem_ready(mem_ready), .hold(hold), .ir_load(ir_load), .pc_en(pc_en),
      .pc_src(pc_src), .RegWrite(RegWrite), .RegDst(RegDst), .MemtoReg(MemtoReg),
      .Jal(Jal), .ALUSrc(ALUSrc), .ALUOp(ALUOp), .MemRead(MemRead),
      .MemWrite(MemWrite), .illegal_op(illegal_op), .bus_error(bus_error),
      .retire_count(retire_count), .state(state)
   );

   always #5 clock = ~clock;

   typedef struct {
      logic        hold, mem_ready, zero;
      logic [31:0] instr;
      logic        ir_load, pc_en;
      logic [1:0]  pc_src;
      logic        reg_write, mem_read, mem_write, illegal, bus_err;
      logic [31:0] retire;
      logic [5:0]  cw;
      logic [2:0]  st;
   } cyc_t;

   cyc_t        q[$];
   int          n_checks = 0, n_pass = 0;
   logic [31:0] m_retire = 32'd0;
   logic [5:0]  m_cw = 6'd0;
   int          lat = 0, last_lat = 0, mr_cycles = 0, mw_cycles = 0;
   int          cyc_idx = 0, first_ir = -1;
   logic [1:0]  last_src = 2'd0;
   logic        last_bus = 1'b0, last_ill = 1'b0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
   endtask

   // Control word {RegDst, MemtoReg, Jal, ALUSrc, ALUOp} straight from the opcode table.
   function automatic logic [5:0] model_cw(input logic [5:0] op);
      case (op)
         6'h00:                      return 6'b1000_10;
         6'h23:                      return 6'b0101_00;
         6'h2B:                      return 6'b0001_00;
         6'h04, 6'h05:               return 6'b0000_01;
         6'h03:                      return 6'b0010_00;
         6'h08, 6'h09:               return 6'b0001_00;
         6'h0A, 6'h0B, 6'h0C, 6'h0D,
         6'h0E, 6'h0F:               return 6'b0001_11;
         default:                    return 6'b0000_00;
      endcase
   endfunction

   function automatic logic model_legal(input logic [5:0] op);
      return op inside {6'h00, 6'h02, 6'h03, 6'h04, 6'h05, 6'h08, 6'h09, 6'h0A,
                        6'h0B, 6'h0C, 6'h0D, 6'h0E, 6'h0F, 6'h23, 6'h2B};
   endfunction

   function automatic cyc_t new_rec(input logic [31:0] instr, input logic [2:0] st);
      cyc_t r;
      r.hold = 1'($urandom); r.mem_ready = 1'($urandom); r.zero = 1'($urandom);
      r.instr = instr; r.ir_load = 1'b0; r.pc_en = 1'b0; r.pc_src = 2'd0;
      r.reg_write = 1'b0; r.mem_read = 1'b0; r.mem_write = 1'b0;
      r.illegal = 1'b0; r.bus_err = 1'b0; r.retire = m_retire; r.cw = m_cw; r.st = st;
      return r;
   endfunction

   // delay: MEM cycle index at which mem_ready arrives (>= TMO means never).
   task automatic gen_instr(input logic [31:0] instr, input logic zero_v, input int delay, input int hold_n);
      cyc_t r;
      logic [5:0] op = instr[31:26];
      logic [5:0] fn = instr[5:0];
      for (int h = 0; h < hold_n; h++) begin
         r = new_rec(instr, 3'd0); r.hold = 1'b1; q.push_back(r);
      end
      r = new_rec(instr, 3'd0); r.hold = 1'b0; r.ir_load = 1'b1; q.push_back(r);
      r = new_rec(instr, 3'd1);
      if (!model_legal(op)) begin
         r.illegal = 1'b1; r.pc_en = 1'b1; q.push_back(r); m_cw = 6'd0; return;
      end
      q.push_back(r);
      m_cw = model_cw(op);
      r = new_rec(instr, 3'd2); r.zero = zero_v;
      if (op == 6'h04 || op == 6'h05) begin
         r.pc_en = 1'b1; r.pc_src = (zero_v ^ (op == 6'h05)) ? 2'd1 : 2'd0;
         q.push_back(r); m_retire = m_retire + 1; return;
      end
      if (op == 6'h02 || (op == 6'h00 && fn == 6'h08)) begin
         r.pc_en = 1'b1; r.pc_src = (op == 6'h02) ? 2'd2 : 2'd3;
         q.push_back(r); m_retire = m_retire + 1; return;
      end
      q.push_back(r);
      if (op == 6'h23 || op == 6'h2B) begin
         for (int k = 0; k < TMO; k++) begin
            r = new_rec(instr, 3'd3);
            r.mem_read = (op == 6'h23); r.mem_write = (op == 6'h2B);
            r.mem_ready = (k == delay);
            if (k == delay) begin
               if (op == 6'h2B) begin
                  r.pc_en = 1'b1; q.push_back(r); m_retire = m_retire + 1; return;
               end
               q.push_back(r); break;
            end
            if (k == TMO - 1) begin
               r.bus_err = 1'b1; r.pc_en = 1'b1; q.push_back(r); return;
            end
            q.push_back(r);
         end
      end
      r = new_rec(instr, 3'd4); r.reg_write = 1'b1; r.pc_en = 1'b1;
      r.pc_src = (op == 6'h03) ? 2'd2 : 2'd0;
      q.push_back(r); m_retire = m_retire + 1;
   endtask

   // Drives each queued cycle just after posedge, compares on the negedge.
   task automatic run_cycles(input int n);
      cyc_t r;
      for (int i = 0; i < n && q.size() > 0; i++) begin
         r = q.pop_front();
         hold = r.hold; mem_ready = r.mem_ready; zero = r.zero; Instruction = r.instr;
         @(negedge clock);
         chk("state", state, r.st);
         chk("ir_load", ir_load, r.ir_load);
         chk("pc_en", pc_en, r.pc_en);
         chk("pc_src", pc_src, r.pc_src);
         chk("RegWrite", RegWrite, r.reg_write);
         chk("MemRead", MemRead, r.mem_read);
         chk("MemWrite", MemWrite, r.mem_write);
         chk("illegal_op", illegal_op, r.illegal);
         chk("bus_error", bus_error, r.bus_err);
         chk("retire_count", retire_count, r.retire);
         chk("ctrl_word", {RegDst, MemtoReg, Jal, ALUSrc, ALUOp}, r.cw);
         if (ir_load) begin
            lat = 1;
            if (first_ir < 0) first_ir = cyc_idx;
         end else lat++;
         if (pc_en) begin
            last_lat = lat; last_src = pc_src; last_bus = bus_error; last_ill = illegal_op;
         end
         if (MemRead) mr_cycles++;
         if (MemWrite) mw_cycles++;
         cyc_idx++;
         @(posedge clock); #1;
      end
   endtask

   function automatic logic [31:0] rand_instr();
      logic [5:0]  ops[16] = '{6'h00, 6'h02, 6'h03, 6'h04, 6'h05, 6'h08, 6'h09, 6'h0A,
                               6'h0B, 6'h0C, 6'h0D, 6'h0E, 6'h0F, 6'h23, 6'h2B, 6'h00};
      logic [5:0]  bad[4] = '{6'h01, 6'h10, 6'h20, 6'h3F};
      logic [31:0] w = $urandom;
      int          s = int'($urandom_range(0, 17));
      if (s >= 16) w[31:26] = bad[$urandom_range(0, 3)];
      else begin
         w[31:26] = ops[s];
         if (ops[s] == 6'h00 && $urandom_range(0, 3) == 0) w[5:0] = 6'h08;
      end
      return w;
   endfunction

   initial begin
      logic [31:0] w;
      reset = 1'b0; hold = 1'b0;
      repeat (3) @(posedge clock);
      @(negedge clock);
      chk("rst_state", state, 3'd0);
      chk("rst_outputs", {ir_load, pc_en, pc_src, RegWrite, MemRead, MemWrite, illegal_op,
                          bus_error, RegDst, MemtoReg, Jal, ALUSrc, ALUOp}, 32'd0);
      chk("rst_retire", retire_count, 32'd0);
      @(posedge clock); #1 reset = 1'b1;

      w = {6'h00, 20'(($urandom)), 6'h20};
      gen_instr(w, 1'b0, 0, 0); run_cycles(q.size());
      chk("add_latency", last_lat, 4);
      chk("add_retire", retire_count, 1);

      w = {6'h23, 26'($urandom)}; mr_cycles = 0;
      gen_instr(w, 1'b0, 2, 0); run_cycles(q.size());
      chk("lw_memread_cycles", mr_cycles, 3);
      chk("lw_latency", last_lat, 7);
      chk("lw_pc_src", last_src, 0);

      w = {6'h04, 26'($urandom)};
      gen_instr(w, 1'b1, 0, 0); run_cycles(q.size());
      chk("beq_latency", last_lat, 3);
      chk("beq_pc_src", last_src, 1);
      w = {6'h05, 26'($urandom)};
      gen_instr(w, 1'b1, 0, 0); run_cycles(q.size());
      chk("bne_pc_src", last_src, 0);

      w = {6'h03, 26'($urandom)};
      gen_instr(w, 1'b0, 0, 0); run_cycles(q.size());
      chk("jal_latency", last_lat, 4);
      chk("jal_pc_src", last_src, 2);

      w = {6'h2B, 26'($urandom)}; mw_cycles = 0;
      gen_instr(w, 1'b0, 1000, 0); run_cycles(q.size());
      chk("sw_tmo_memwrite_cycles", mw_cycles, 16);
      chk("sw_tmo_bus_error", last_bus, 1);
      chk("sw_tmo_retire", retire_count, 5);

      w = {6'h3F, 26'($urandom)};
      gen_instr(w, 1'b0, 0, 0); run_cycles(q.size());
      chk("illegal_latency", last_lat, 2);
      chk("illegal_pulse", last_ill, 1);

      w = {6'h00, 20'($urandom), 6'h20}; cyc_idx = 0; first_ir = -1;
      gen_instr(w, 1'b0, 0, 5); run_cycles(q.size());
      chk("hold_first_ir_cycle", first_ir, 5);
      chk("directed_retire", retire_count, 6);

      // Abort a lw waiting in MEM with an asynchronous reset.
      w = {6'h23, 26'($urandom)};
      gen_instr(w, 1'b0, 1000, 0); run_cycles(5);
      mem_ready = 1'b0; hold = 1'b0;
      #1 chk("abort_pre_state", state, 3'd3);
      reset = 1'b0;
      #1;
      chk("abort_state", state, 3'd0);
      chk("abort_outputs", {ir_load, pc_en, pc_src, RegWrite, MemRead, MemWrite, illegal_op,
                            bus_error, RegDst, MemtoReg, Jal, ALUSrc, ALUOp}, 32'd0);
      chk("abort_retire", retire_count, 32'd0);
      q.delete(); m_retire = 32'd0; m_cw = 6'd0;
      @(posedge clock); #1 reset = 1'b1;

      for (int i = 0; i < 300; i++)
         gen_instr(rand_instr(), 1'($urandom), int'($urandom_range(0, TMO + 3)),
                   int'($urandom_range(0, 2)));
      run_cycles(q.size());

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
